// File: rtl/rnd_key_gen.sv
// DES key-schedule engine: PC-1, per-round C/D left rotations and PC-2, writing
// round keys K1..K16 to round-key storage addresses 0..15, one per cycle.
module rnd_key_gen #(
   parameter int ADDR_WIDTH = 4,
   parameter int ROUNDS     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [63:0]           key_in,
   output logic                  ks_mode,
   output logic [ADDR_WIDTH-1:0] ks_addr,
   output logic [47:0]           ks_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

   // FIPS 46-3 permutation tables; entry i names the source bit (1 = MSB).
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   function automatic logic [55:0] f_pc1(input logic [63:0] k);
      logic [55:0] v;
      v = '0;
      for (int i = 0; i < 56; i++)
         v[6'(55 - i)] = k[6'(64 - PC1_TAB[6'(i)])];
      return v;
   endfunction

   function automatic logic [47:0] f_pc2(input logic [55:0] cd);
      logic [47:0] v;
      v = '0;
      for (int i = 0; i < 48; i++)
         v[6'(47 - i)] = cd[6'(56 - PC2_TAB[6'(i)])];
      return v;
   endfunction

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [27:0]           r_c, r_d, w_c_nxt, w_d_nxt;
   logic                  r_mode, w_mode_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [47:0]           r_data, w_data_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_done, w_done_nxt;

   logic [55:0]           w_pc1;
   logic                  w_rot1;
   logic [27:0]           w_c_rot, w_d_rot;

   assign w_pc1  = f_pc1(key_in);
   // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
   assign w_rot1 = r_cnt inside {4'd0, 4'd1, 4'd8, 4'd15};
   assign w_c_rot = w_rot1 ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
   assign w_d_rot = w_rot1 ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_c_nxt     = r_c;
      w_d_nxt     = r_d;
      w_mode_nxt  = r_mode;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_mode_nxt = 1'b0;
            w_addr_nxt = '0;
            if (start) begin
               w_c_nxt     = w_pc1[55:28];
               w_d_nxt     = w_pc1[27:0];
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_GEN;
            end
         end
         S_GEN: begin
            w_c_nxt    = w_c_rot;
            w_d_nxt    = w_d_rot;
            w_data_nxt = f_pc2({w_c_rot, w_d_rot});
            w_addr_nxt = r_cnt;
            w_mode_nxt = 1'b1;
            w_cnt_nxt  = r_cnt + 1'b1;
            if (r_cnt == ADDR_WIDTH'(ROUNDS - 1))
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_mode_nxt  = 1'b0;
            w_addr_nxt  = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments; reset is asynchronous so outputs drop at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_c     <= '0;
         r_d     <= '0;
         r_mode  <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_c     <= w_c_nxt;
         r_d     <= w_d_nxt;
         r_mode  <= w_mode_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign ks_mode = r_mode;
   assign ks_addr = r_addr;
   assign ks_data = r_data;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule
